// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single data_memory port between the pipeline MEM
// stage (core) and a debug/program-loader master (dbg).
//
// Core has fixed priority. A burst counter lets dbg in after MAX_CORE_BURST
// consecutive core grants while dbg waits. dbg may lock the port (LOCKED state).
// Grants are combinational because data_memory registers its inputs. Read data
// comes back one cycle after the grant and is routed to the owner of that read.
//
// Ports:
//   clock, reset                      clock; synchronous active-high reset
//   core_req/addr/wdata/wren/mode     core request (EX-stage signals)
//   core_gnt, core_stall              core grant; stall = req && !gnt
//   core_rdata, core_rvalid           core read return
//   dbg_req/lock/addr/wdata/wren/mode dbg request; lock keeps the port for dbg
//   dbg_gnt, dbg_rdata, dbg_rvalid    dbg grant and read return
//   mem_addr/wdata/wren/mode          muxed request to data_memory
//   mem_rdata                         data_memory q (1-cycle latency)
module data_mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_CORE_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic [DATA_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic                  core_wren,
    input  logic [1:0]            core_mode,
    output logic                  core_gnt,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    input  logic                  dbg_req,
    input  logic                  dbg_lock,
    input  logic [DATA_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic                  dbg_wren,
    input  logic [1:0]            dbg_mode,
    output logic                  dbg_gnt,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wren,
    output logic [1:0]            mem_mode,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (MAX_CORE_BURST < 1 || MAX_CORE_BURST > 15) begin : g_bad_burst
        $error("MAX_CORE_BURST must be in 1..15");
    end

    typedef enum logic [0:0] {StArb, StLocked} state_e;
    typedef enum logic [1:0] {OwnNone, OwnCore, OwnDbg} owner_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_CORE_BURST);

    state_e     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    owner_e     owner_q, owner_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StArb;
            burst_q <= '0;
            owner_q <= OwnNone;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:    if (dbg_gnt && dbg_lock) state_d = StLocked;
            // The exit cycle still grants dbg; core only sees the port next cycle.
            StLocked: if (!dbg_lock || !dbg_req) state_d = StArb;
            default:  state_d = StArb;
        endcase
    end

    always_comb begin
        burst_d = burst_q;
        if (dbg_gnt || !dbg_req) begin
            burst_d = '0;
        end else if (core_gnt && burst_q < MaxBurst) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_comb begin
        owner_d = OwnNone;
        if (core_gnt && !core_wren) begin
            owner_d = OwnCore;
        end else if (dbg_gnt && !dbg_wren) begin
            owner_d = OwnDbg;
        end
    end

    // Output logic: grants (suppressed during reset)
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StArb: begin
                    if (core_req && (!dbg_req || burst_q < MaxBurst)) begin
                        core_gnt = 1'b1;
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                end
                StLocked: dbg_gnt = dbg_req;
                default: ;
            endcase
        end
    end

    assign core_stall = core_req && !core_gnt;

    // Memory-side mux; all zero with no grant so no spurious write escapes.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_mode  = 2'b00;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_wren  = core_wren;
            mem_mode  = core_mode;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wren  = dbg_wren;
            mem_mode  = dbg_mode;
        end
    end

    // Read return; gated by reset so an owner captured before reset never leaks.
    always_comb begin
        core_rvalid = !reset && (owner_q == OwnCore);
        dbg_rvalid  = !reset && (owner_q == OwnDbg);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        dbg_rdata   = dbg_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations plus
// a per-cycle behavioural reference model and a simple data_memory model.
module tb_data_mem_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          core_req, core_wren, core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_addr, core_wdata, core_rdata;
    logic [1:0]    core_mode;
    logic          dbg_req, dbg_lock, dbg_wren, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [1:0]    dbg_mode;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_wren;
    logic [1:0]    mem_mode;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_arbiter #(.DATA_WIDTH(DW), .MAX_CORE_BURST(MAXB)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wren(core_wren), .core_mode(core_mode), .core_gnt(core_gnt),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_wren(dbg_wren), .dbg_mode(dbg_mode), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_mode(mem_mode), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // data_memory model: registered read, write on mem_wren.
    logic [31:0] envmem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (envmem.exists(a)) return envmem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clock) begin
        mem_rdata <= rd(mem_addr);
        if (mem_wren) envmem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port, how long dbg has waited, pending read.
    bit          m_locked = 0;
    int          m_wait   = 0;
    int          m_owner  = 0;   // 0 none, 1 core, 2 dbg
    logic [31:0] m_data   = '0;

    always @(negedge clock) begin
        logic        ec, ed, ewr, ecv, edv;
        logic [31:0] ea, ew;
        logic [1:0]  em;
        ec = 1'b0;
        ed = 1'b0;
        if (!reset) begin
            if (m_locked) begin
                ed = dbg_req;
            end else begin
                ed = dbg_req && (!core_req || m_wait == MAXB);
                ec = core_req && !ed;
            end
        end
        ea  = ec ? core_addr  : ed ? dbg_addr  : 32'h0;
        ew  = ec ? core_wdata : ed ? dbg_wdata : 32'h0;
        ewr = ec ? core_wren  : ed ? dbg_wren  : 1'b0;
        em  = ec ? core_mode  : ed ? dbg_mode  : 2'b00;
        ecv = !reset && m_owner == 1;
        edv = !reset && m_owner == 2;
        chk("m_core_gnt", core_gnt, ec);
        chk("m_dbg_gnt", dbg_gnt, ed);
        chk("m_core_stall", core_stall, core_req && !ec);
        chk("m_mem_addr", mem_addr, ea);
        chk("m_mem_wdata", mem_wdata, ew);
        chk("m_mem_wren", mem_wren, ewr);
        chk("m_mem_mode", mem_mode, em);
        chk("m_core_rvalid", core_rvalid, ecv);
        chk("m_core_rdata", core_rdata, ecv ? m_data : 32'h0);
        chk("m_dbg_rvalid", dbg_rvalid, edv);
        chk("m_dbg_rdata", dbg_rdata, edv ? m_data : 32'h0);
        chk("m_gnt_exclusive", core_gnt & dbg_gnt, 1'b0);
        if (reset) begin
            m_locked = 0;
            m_wait   = 0;
            m_owner  = 0;
        end else begin
            m_owner = (ec && !core_wren) ? 1 : (ed && !dbg_wren) ? 2 : 0;
            m_data  = rd(ea);
            if (ed || !dbg_req) m_wait = 0;
            else if (ec && m_wait < MAXB) m_wait++;
            m_locked = m_locked ? (dbg_lock && dbg_req) : (ed && dbg_lock);
        end
    end

    task automatic set_core(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic w);
        core_req = r; core_addr = a; core_wdata = d; core_wren = w; core_mode = 2'b10;
    endtask

    task automatic set_dbg(input logic r, input logic l, input logic [31:0] a,
                           input logic [31:0] d, input logic w);
        dbg_req = r; dbg_lock = l; dbg_addr = a; dbg_wdata = d; dbg_wren = w; dbg_mode = 2'b01;
    endtask

    task automatic idle();
        set_core(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
    endtask

    task automatic to_check();
        @(negedge clock);
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    initial begin
        envmem[32'h10]  = 32'hDEAD_BEEF;
        envmem[32'h100] = 32'h1111_0100;
        envmem[32'h200] = 32'h2222_0200;
        reset = 1'b1;
        idle();
        set_core(1, 32'h44, 0, 0);

        // Reset state
        to_check();
        chk("rst_core_gnt", core_gnt, 1'b0);
        chk("rst_stall", core_stall, 1'b1);
        chk("rst_wren", mem_wren, 1'b0);
        chk("rst_rvalid", core_rvalid, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);

        // Core-only read
        to_drive(); reset = 1'b0; set_core(1, 32'h10, 0, 0);
        to_check();
        chk("rd_core_gnt", core_gnt, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_stall", core_stall, 1'b0);
        to_drive(); idle();
        to_check();
        chk("rd_core_rvalid", core_rvalid, 1'b1);
        chk("rd_core_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("rd_dbg_rvalid", dbg_rvalid, 1'b0);

        // Contention: core 4 times, dbg once, core again
        to_drive(); set_core(1, 32'h40, 0, 0); set_dbg(1, 0, 32'h80, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            to_check();
            chk($sformatf("burst_c%0d_core_gnt", c), core_gnt, c != 5);
            chk($sformatf("burst_c%0d_dbg_gnt", c), dbg_gnt, c == 5);
            chk($sformatf("burst_c%0d_stall", c), core_stall, c == 5);
            to_drive();
        end
        idle();
        to_check();

        // Lock: dbg wins after burst, then holds the port for three writes
        to_drive(); set_core(1, 32'h44, 0, 0); set_dbg(1, 1, 32'h0, 32'd1, 1);
        for (int c = 1; c <= 4; c++) begin
            to_check();
            chk($sformatf("lock_c%0d_core_gnt", c), core_gnt, 1'b1);
            to_drive();
        end
        for (int c = 0; c < 3; c++) begin
            to_check();
            chk($sformatf("lock_w%0d_dbg_gnt", c), dbg_gnt, 1'b1);
            chk($sformatf("lock_w%0d_wren", c), mem_wren, 1'b1);
            chk($sformatf("lock_w%0d_addr", c), mem_addr, 32'(c * 4));
            chk($sformatf("lock_w%0d_wdata", c), mem_wdata, 32'(c + 1));
            chk($sformatf("lock_w%0d_stall", c), core_stall, 1'b1);
            to_drive();
            if (c < 2) set_dbg(1, 1, 32'((c + 1) * 4), 32'(c + 2), 1);
            else set_dbg(1, 0, 32'h8, 0, 0);
        end
        to_check();
        chk("unlock_exit_dbg_gnt", dbg_gnt, 1'b1);
        chk("unlock_exit_core_gnt", core_gnt, 1'b0);
        to_drive();
        to_check();
        chk("unlock_core_gnt", core_gnt, 1'b1);
        chk("unlock_dbg_rvalid", dbg_rvalid, 1'b1);
        chk("unlock_dbg_rdata", dbg_rdata, 32'd3);
        to_drive(); idle();
        to_check();

        // dbg write produces no rvalid; core reads it back
        to_drive(); set_dbg(1, 0, 32'h20, 32'h55, 1);
        to_check();
        chk("wr_dbg_gnt", dbg_gnt, 1'b1);
        chk("wr_wren", mem_wren, 1'b1);
        chk("wr_addr", mem_addr, 32'h20);
        to_drive(); idle();
        to_check();
        chk("wr_no_core_rvalid", core_rvalid, 1'b0);
        chk("wr_no_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("wr_wren_off", mem_wren, 1'b0);
        to_drive(); set_core(1, 32'h20, 0, 0);
        to_check();
        to_drive(); idle();
        to_check();
        chk("wr_readback_rvalid", core_rvalid, 1'b1);
        chk("wr_readback_rdata", core_rdata, 32'h55);

        // Reset mid-operation clears read owner and burst counter
        to_drive(); set_core(1, 32'h10, 0, 0); set_dbg(1, 0, 32'h80, 0, 0);
        for (int c = 1; c <= 2; c++) begin
            to_check();
            chk($sformatf("prerst_c%0d_core_gnt", c), core_gnt, 1'b1);
            to_drive();
        end
        reset = 1'b1;
        to_check();
        chk("midrst_core_gnt", core_gnt, 1'b0);
        chk("midrst_dbg_gnt", dbg_gnt, 1'b0);
        chk("midrst_wren", mem_wren, 1'b0);
        chk("midrst_rvalid", core_rvalid, 1'b0);
        to_drive(); reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            to_check();
            if (c == 1) chk("postrst_rvalid", core_rvalid, 1'b0);
            chk($sformatf("postrst_c%0d_core_gnt", c), core_gnt, c != 5);
            chk($sformatf("postrst_c%0d_dbg_gnt", c), dbg_gnt, c == 5);
            to_drive();
        end
        idle();
        to_check();

        // Alternating reads, then a core write
        to_drive(); set_core(1, 32'h100, 0, 0);
        to_check();
        chk("alt_core_gnt", core_gnt, 1'b1);
        to_drive(); set_core(0, 0, 0, 0); set_dbg(1, 0, 32'h200, 0, 0);
        to_check();
        chk("alt_dbg_gnt", dbg_gnt, 1'b1);
        chk("alt_core_rvalid", core_rvalid, 1'b1);
        chk("alt_core_rdata", core_rdata, 32'h1111_0100);
        chk("alt_dbg_rvalid0", dbg_rvalid, 1'b0);
        to_drive(); idle(); set_core(1, 32'h30, 32'hAB, 1);
        to_check();
        chk("alt_dbg_rvalid", dbg_rvalid, 1'b1);
        chk("alt_dbg_rdata", dbg_rdata, 32'h2222_0200);
        chk("alt_core_rvalid0", core_rvalid, 1'b0);
        chk("cwr_wren", mem_wren, 1'b1);
        chk("cwr_wdata", mem_wdata, 32'hAB);
        chk("cwr_mode", mem_mode, 2'b10);
        to_drive(); idle();
        to_check();
        chk("cwr_no_rvalid", core_rvalid, 1'b0);
        to_drive();
        to_drive();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
